// File: rtl/ggt_batch_ctrl_if.sv
// Signal bundle between the batch controller and its environment: operand ROM
// read port, ggt_top start/valid handshake and result RAM write port.
interface ggt_batch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  run_i;
  logic [ADDR_W-1:0]     rd_addr_o;
  logic [2*DATA_W-1:0]   rd_data_i;
  logic [DATA_W-1:0]     zahl1_o;
  logic [DATA_W-1:0]     zahl2_o;
  logic                  start_o;
  logic                  valid_i;
  logic [DATA_W-1:0]     ergebnis_i;
  logic [ADDR_W-1:0]     wr_addr_o;
  logic [DATA_W-1:0]     wr_data_o;
  logic                  wr_en_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [ADDR_W:0]       count_o;

  modport master (
    input  run_i, rd_data_i, valid_i, ergebnis_i,
    output rd_addr_o, zahl1_o, zahl2_o, start_o, wr_addr_o, wr_data_o,
           wr_en_o, busy_o, done_o, error_o, count_o
  );

  modport slave (
    output run_i, rd_data_i, valid_i, ergebnis_i,
    input  rd_addr_o, zahl1_o, zahl2_o, start_o, wr_addr_o, wr_data_o,
           wr_en_o, busy_o, done_o, error_o, count_o
  );
endinterface

// File: rtl/ggt_batch_ctrl.sv
// Batch controller around ggt_top: fetches operand pairs from a synchronous ROM,
// runs each through ggt_top (or short-cuts zero operands) and writes results to RAM.
module ggt_batch_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int N_PAIRS = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic            clk,
  input  logic            rst_i,
  ggt_batch_ctrl_if.master bus
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, GUARD, WAIT, WRITE, DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     count;
  logic [TO_W-1:0]     to_cnt;
  logic [DATA_W-1:0]   zahl1;
  logic [DATA_W-1:0]   zahl2;
  logic [DATA_W-1:0]   wr_data;
  logic                start;
  logic                wr_en;
  logic                busy;
  logic                done;
  logic                error;
  logic [DATA_W-1:0]   rd_hi;
  logic [DATA_W-1:0]   rd_lo;

  assign rd_hi = bus.rd_data_i[2*DATA_W-1:DATA_W];
  assign rd_lo = bus.rd_data_i[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state   <= IDLE;
      idx     <= '0;
      count   <= '0;
      to_cnt  <= '0;
      zahl1   <= '0;
      zahl2   <= '0;
      wr_data <= '0;
      start   <= 1'b0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      start <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run_i) begin
            idx   <= '0;
            count <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          zahl1 <= rd_hi;
          zahl2 <= rd_lo;
          // ggT(a,0)=a and ggT(0,0)=0, so OR of the halves is the result.
          if (rd_hi == '0 || rd_lo == '0) begin
            wr_data <= rd_hi | rd_lo;
            wr_en   <= 1'b1;
            state   <= WRITE;
          end else begin
            start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= GUARD;
        GUARD: begin
          // valid_i may still be high from the previous pair here; never sample it.
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (bus.valid_i) begin
            wr_data <= bus.ergebnis_i;
            wr_en   <= 1'b1;
            state   <= WRITE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            wr_data <= '1;
            wr_en   <= 1'b1;
            error   <= 1'b1;
            state   <= WRITE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WRITE: begin
          count <= count + (ADDR_W + 1)'(1);
          if (idx == ADDR_W'(N_PAIRS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // idx only changes on the way into FETCH, so it is valid as ROM and RAM address.
  assign bus.rd_addr_o = idx;
  assign bus.wr_addr_o = idx;
  assign bus.wr_data_o = wr_data;
  assign bus.wr_en_o   = wr_en;
  assign bus.zahl1_o   = zahl1;
  assign bus.zahl2_o   = zahl2;
  assign bus.start_o   = start;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.error_o   = error;
  assign bus.count_o   = count;

endmodule

// File: tb/tb_ggt_batch_ctrl.sv
// Bench for ggt_batch_ctrl: ROM and ggt_top stand-ins, event monitor and a
// cycle-level reference of the batch computed from the operand table.
module tb_ggt_batch_ctrl;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 2;
  localparam int N_PAIRS = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ggt_batch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ggt_batch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_PAIRS(N_PAIRS), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {int cyc; int addr; int data;} wr_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   k_run = 0;
  logic [31:0] rom [N_PAIRS];
  wr_t  wr_q[$];
  int   start_q[$];
  int   done_q[$];
  int   busy_cnt = 0;
  bit   err_done = 0;
  bit   busy_done = 0;
  int   dly = 5;
  bit   sticky = 0;
  int   age = 0;
  bit   pend = 0;
  logic [15:0] res = '0;

  function automatic logic [15:0] gcd(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b, t;
    a = a_in; b = b_in;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.rd_data_i <= rom[bus.rd_addr_o];

  // ggt_top stand-in: result valid dly cycles after start (dly=0: never); in sticky
  // mode valid stays high with the old result through the cycle after start.
  initial begin bus.valid_i = 1'b0; bus.ergebnis_i = '0; bus.run_i = 1'b0; bus.rd_data_i = '0; end
  always @(posedge clk) begin
    if (bus.start_o) begin
      age  <= 1;
      pend <= 1'b1;
      res  <= gcd(bus.zahl1_o, bus.zahl2_o);
      if (!sticky) bus.valid_i <= 1'b0;
    end else if (pend) begin
      age <= age + 1;
      if (age + 1 == dly) begin
        bus.valid_i    <= 1'b1;
        bus.ergebnis_i <= res;
        pend           <= 1'b0;
      end else if (age + 1 == 2) begin
        bus.valid_i <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.start_o) start_q.push_back(cyc);
      if (bus.wr_en_o) wr_q.push_back('{cyc, int'(bus.wr_addr_o), int'(bus.wr_data_o)});
      if (bus.done_o) begin
        done_q.push_back(cyc);
        err_done  = bus.error_o;
        busy_done = bus.busy_o;
      end
      if (bus.busy_o) busy_cnt++;
    end
  end

  function automatic longint outs();
    return longint'({bus.start_o, bus.wr_en_o, bus.busy_o, bus.done_o, bus.error_o,
                     bus.count_o, bus.zahl1_o, bus.zahl2_o, bus.wr_addr_o,
                     bus.wr_data_o, bus.rd_addr_o});
  endfunction

  task automatic fill_rom(input int zero_pct);
    int g;
    for (int i = 0; i < N_PAIRS; i++) begin
      if ($urandom_range(0, 99) < zero_pct) begin
        g = $urandom_range(0, 2);
        rom[i][31:16] = (g == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        rom[i][15:0]  = (g == 1) ? 16'd0 : ((g == 2) ? 16'd0 : 16'($urandom_range(1, 65535)));
        if (g == 2) rom[i][31:16] = 16'd0;
      end else begin
        g = $urandom_range(1, 300);
        rom[i][31:16] = 16'(g * $urandom_range(1, 200));
        rom[i][15:0]  = 16'(g * $urandom_range(1, 200));
      end
    end
  endtask

  task automatic start_run();
    wr_q.delete(); start_q.delete(); done_q.delete(); busy_cnt = 0;
    @(posedge clk); #1 bus.run_i = 1'b1;
    @(posedge clk); #1 bus.run_i = 1'b0;
    k_run = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() == 0 && n < 3000) begin @(posedge clk); n++; end
    chk("done_seen", longint'(done_q.size() > 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_batch(input bit hang, input int d);
    int fetch, st_i, exp_wr, exp_st;
    logic [15:0] a, b, ed;
    bit any_nz;
    fetch = k_run; st_i = 0; exp_wr = k_run; any_nz = 0;
    chk("n_writes", wr_q.size(), N_PAIRS);
    for (int i = 0; i < N_PAIRS && i < wr_q.size(); i++) begin
      a = rom[i][31:16]; b = rom[i][15:0];
      if (a == 0 || b == 0) begin
        ed = a | b;
        exp_wr = fetch + 2;
      end else begin
        any_nz = 1;
        ed = hang ? 16'hFFFF : gcd(a, b);
        exp_st = fetch + 2;
        chk("start_cyc", (st_i < start_q.size()) ? start_q[st_i] : -1, exp_st);
        exp_wr = exp_st + (hang ? TIMEOUT + 2 : d + 1);
        st_i++;
      end
      chk("wr_addr", wr_q[i].addr, i);
      chk("wr_data", wr_q[i].data, ed);
      chk("wr_cyc", wr_q[i].cyc, exp_wr);
      fetch = exp_wr + 1;
    end
    chk("n_starts", start_q.size(), st_i);
    chk("n_done", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cyc", done_q[0], exp_wr + 1);
    chk("busy_at_done", busy_done, 0);
    chk("busy_cycles", busy_cnt, exp_wr - k_run + 1);
    chk("err_at_done", err_done, hang && any_nz);
    chk("count", bus.count_o, N_PAIRS);
    chk("error", bus.error_o, hang && any_nz);
    chk("zahl1_hold", bus.zahl1_o, rom[N_PAIRS-1][31:16]);
    chk("zahl2_hold", bus.zahl2_o, rom[N_PAIRS-1][15:0]);
  endtask

  initial begin
    int n;
    int nw;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs(), 0);
    rst = 1'b0;

    // Directed pairs with known results, fixed 5-cycle ggt_top latency.
    rom[0] = {16'd685, 16'd744};
    rom[1] = {16'd24255, 16'd12540};
    fill_rom(0);
    rom[0] = {16'd685, 16'd744};
    rom[1] = {16'd24255, 16'd12540};
    dly = 5; sticky = 0;
    start_run();
    wait_done();
    check_batch(0, dly);
    if (wr_q.size() >= 2) begin
      chk("ggt_685_744", wr_q[0].data, 1);
      chk("ggt_24255_12540", wr_q[1].data, 165);
    end

    // Zero-operand short-cut only: no start pulses.
    rom[0] = {16'd0, 16'd48};
    rom[1] = {16'd0, 16'd0};
    rom[2] = {16'd36, 16'd0};
    rom[3] = {16'd0, 16'd7};
    start_run();
    wait_done();
    check_batch(0, dly);
    chk("zero_no_start", start_q.size(), 0);

    // ggt_top never answers: every non-zero pair times out.
    fill_rom(20);
    rom[0] = {16'd12, 16'd18};
    dly = 0;
    start_run();
    wait_done();
    check_batch(1, 0);

    // Next accepted run clears the sticky error.
    fill_rom(20);
    dly = $urandom_range(2, 6);
    start_run();
    chk("error_cleared", bus.error_o, 0);
    wait_done();
    check_batch(0, dly);

    // valid held high from previous result; run pulses while busy are ignored.
    fill_rom(0);
    sticky = 1; dly = $urandom_range(2, 4);
    start_run();
    repeat (4) @(posedge clk);
    #1 bus.run_i = 1'b1;
    @(posedge clk); #1 bus.run_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.run_i = 1'b1;
    @(posedge clk); #1 bus.run_i = 1'b0;
    wait_done();
    check_batch(0, dly);

    // Reset during WAIT of the third pair.
    fill_rom(0);
    sticky = 0; dly = 6;
    start_run();
    n = 0;
    while (start_q.size() < 3 && n < 500) begin @(posedge clk); n++; end
    chk("third_start_seen", start_q.size(), 3);
    #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk("mid_reset_outs", outs(), 0);
    rst = 1'b0;
    chk("writes_before_reset", wr_q.size(), 2);
    nw = wr_q.size();
    repeat (40) @(posedge clk);
    #1;
    chk("no_write_after_reset", wr_q.size(), nw);
    chk("no_start_after_reset", start_q.size(), 3);
    chk("no_done_after_reset", done_q.size(), 0);

    start_run();
    wait_done();
    check_batch(0, dly);

    // Randomised batches.
    for (int r = 0; r < 4; r++) begin
      fill_rom(30);
      sticky = 1'($urandom_range(0, 1));
      dly = sticky ? $urandom_range(2, 4) : $urandom_range(2, 8);
      start_run();
      wait_done();
      check_batch(0, dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
